// File: rtl/sreg_wb_pkg.sv
// Shared types for the scalar register file writeback path: producer
// identifiers and the request bundle each producer presents to the arbiter.
package sreg_wb_pkg;

    localparam int NUM_WB_SRC = 3;
    localparam int RD_W       = 5;
    localparam int WB_DATA_W  = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LSU  = 2'd1,
        WB_MDU  = 2'd2,
        WB_NONE = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic                 valid;
        logic [RD_W-1:0]      rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/sreg_wb_arbiter_if.sv
// Writeback bus between the three result producers, dispatch and the
// register file write port. The arbiter sits on the slave side.
interface sreg_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
);
    logic                  alu_valid_i;
    logic                  alu_ready_o;
    logic [4:0]            alu_rd_i;
    logic [DATA_WIDTH-1:0] alu_data_i;

    logic                  lsu_valid_i;
    logic                  lsu_ready_o;
    logic [4:0]            lsu_rd_i;
    logic [DATA_WIDTH-1:0] lsu_data_i;

    logic                  mdu_valid_i;
    logic                  mdu_ready_o;
    logic [4:0]            mdu_rd_i;
    logic [DATA_WIDTH-1:0] mdu_data_i;

    logic                  issue_valid_i;
    logic [4:0]            issue_rd_i;
    logic [REG_COUNT-1:0]  busy_o;

    logic [4:0]            rd_addr_o;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  reg_write_en_o;

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        output mdu_valid_i, mdu_rd_i, mdu_data_i,
        output issue_valid_i, issue_rd_i,
        input  alu_ready_o, lsu_ready_o, mdu_ready_o,
        input  busy_o, rd_addr_o, rd_data_o, reg_write_en_o
    );

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  mdu_valid_i, mdu_rd_i, mdu_data_i,
        input  issue_valid_i, issue_rd_i,
        output alu_ready_o, lsu_ready_o, mdu_ready_o,
        output busy_o, rd_addr_o, rd_data_o, reg_write_en_o
    );

endinterface

// File: rtl/sreg_scoreboard.sv
// Pending-write bitmap: dispatch sets a bit when it issues a destination,
// writeback clears it. x0 never becomes pending.
module sreg_scoreboard
    import sreg_wb_pkg::*;
#(
    parameter int REG_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en_i,
    input  logic [RD_W-1:0]      set_idx_i,
    input  logic                 clr_en_i,
    input  logic [RD_W-1:0]      clr_idx_i,
    output logic [REG_COUNT-1:0] busy_o
);

    logic [REG_COUNT-1:0] busy_q, busy_d;

    // Set is applied after clear so a new producer issued to the register
    // being written back in the same cycle keeps it pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
        if (set_en_i) busy_d[set_idx_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: the bitmap is reset (unlike a RAM array) because dispatch reads
    // every bit on the first cycle after reset and must see nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/sreg_wb_arbiter.sv
// Writeback arbiter for the scalar register file: grants one of ALU/LSU/MDU
// per cycle with starvation promotion, registers the write port, tracks RAW.
module sreg_wb_arbiter
    import sreg_wb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_COUNT    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sreg_wb_arbiter_if.slave  bus
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    wb_req_t               alu_req, lsu_req, mdu_req, win;
    wb_src_e               grant;
    logic [CNT_W-1:0]      lsu_cnt_q, lsu_cnt_d, mdu_cnt_q, mdu_cnt_d;
    logic [RD_W-1:0]       rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  wr_en_q, wr_en_d;

    always_comb begin
        alu_req = '{valid: bus.alu_valid_i, rd: bus.alu_rd_i, data: WB_DATA_W'(bus.alu_data_i)};
        lsu_req = '{valid: bus.lsu_valid_i, rd: bus.lsu_rd_i, data: WB_DATA_W'(bus.lsu_data_i)};
        mdu_req = '{valid: bus.mdu_valid_i, rd: bus.mdu_rd_i, data: WB_DATA_W'(bus.mdu_data_i)};
    end

    // Starved sources outrank the ALU; LSU wins when both are starved.
    always_comb begin
        grant = WB_NONE;
        if (!rst_n)                                     grant = WB_NONE;
        else if (lsu_req.valid && lsu_cnt_q == CNT_MAX) grant = WB_LSU;
        else if (mdu_req.valid && mdu_cnt_q == CNT_MAX) grant = WB_MDU;
        else if (alu_req.valid)                         grant = WB_ALU;
        else if (lsu_req.valid)                         grant = WB_LSU;
        else if (mdu_req.valid)                         grant = WB_MDU;
    end

    assign bus.alu_ready_o = (grant == WB_ALU);
    assign bus.lsu_ready_o = (grant == WB_LSU);
    assign bus.mdu_ready_o = (grant == WB_MDU);

    function automatic logic [CNT_W-1:0] next_cnt(input logic valid, input logic granted,
                                                  input logic [CNT_W-1:0] cnt);
        if (!valid || granted) return '0;
        if (cnt != CNT_MAX)    return cnt + CNT_W'(1);
        return cnt;
    endfunction

    // NOTE: win and every *_d get a default before any branch so no path
    // leaves them unassigned, which would otherwise infer a latch.
    always_comb begin
        win = '0;
        unique case (grant)
            WB_ALU:  win = alu_req;
            WB_LSU:  win = lsu_req;
            WB_MDU:  win = mdu_req;
            default: win = '0;
        endcase

        lsu_cnt_d = next_cnt(lsu_req.valid, grant == WB_LSU, lsu_cnt_q);
        mdu_cnt_d = next_cnt(mdu_req.valid, grant == WB_MDU, mdu_cnt_q);

        // A grant to x0 completes the handshake but leaves the port untouched.
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        wr_en_d   = 1'b0;
        if (win.valid && win.rd != '0) begin
            rd_addr_d = win.rd;
            rd_data_d = DATA_WIDTH'(win.data);
            wr_en_d   = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsu_cnt_q <= '0;
            mdu_cnt_q <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            lsu_cnt_q <= lsu_cnt_d;
            mdu_cnt_q <= mdu_cnt_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign bus.rd_addr_o      = rd_addr_q;
    assign bus.rd_data_o      = rd_data_q;
    assign bus.reg_write_en_o = wr_en_q;

    sreg_scoreboard #(
        .REG_COUNT (REG_COUNT)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en_i  (bus.issue_valid_i),
        .set_idx_i (bus.issue_rd_i),
        .clr_en_i  (win.valid),
        .clr_idx_i (win.rd),
        .busy_o    (bus.busy_o)
    );

endmodule

// File: doc/sreg_wb_arbiter.md
Name: sreg_wb_arbiter

Overview:
- Write-side companion to the scalar register file. Collects results from three producers (ALU, LSU load path, MDU mul/div) over valid/ready handshakes.
- Grants at most one producer per cycle and drives the register file write port (rd_addr, rd_data, reg_write_en) from a registered output stage.
- Keeps a per-register pending-write scoreboard that dispatch uses to detect RAW hazards.

Parameters:
- DATA_WIDTH, 32, width of write data.
- REG_COUNT, 32, number of architectural registers and busy bits.
- STARVE_LIMIT, 4, consecutive lost-arbitration cycles after which LSU or MDU is promoted to top priority.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- alu_valid_i  input  1  ALU result valid
- alu_ready_o  output  1  ALU result accepted this cycle
- alu_rd_i  input  5  ALU destination register
- alu_data_i  input  DATA_WIDTH  ALU result
- lsu_valid_i / lsu_ready_o / lsu_rd_i / lsu_data_i  as ALU, for the load path
- mdu_valid_i / mdu_ready_o / mdu_rd_i / mdu_data_i  as ALU, for mul/div
- issue_valid_i  input  1  dispatch marks a destination pending
- issue_rd_i  input  5  register to mark pending
- busy_o  output  REG_COUNT  pending-write bitmap (bit i = xi awaiting writeback)
- rd_addr_o  output  5  register file write address
- rd_data_o  output  DATA_WIDTH  register file write data
- reg_write_en_o  output  1  register file write enable

Behaviour:
- Reset (async, rst_n low):
  - rd_addr_o=0, rd_data_o=0, reg_write_en_o=0.
  - busy_o=0, both starvation counters=0.
  - All ready outputs=0 while rst_n is low.
- Handshake:
  - A transfer occurs when valid && ready are high on a rising edge.
  - ready is combinational from the valids and the counter state.
  - Exactly one ready is high when any valid is high; all readies are 0 when no valid is high.
  - A ready never asserts for a source whose valid is low.
  - A producer holds rd and data stable until it is granted.
- Priority:
  - Default order is ALU > LSU > MDU.
  - A starved source (its counter == STARVE_LIMIT) outranks the ALU.
  - If LSU and MDU are both starved, LSU wins.
- Starvation counters (LSU and MDU only):
  - Increment when the source is valid and not granted.
  - Saturate at STARVE_LIMIT.
  - Clear on grant, or when the source's valid is low.
- Latency:
  - A grant in cycle N produces the registered output in cycle N+1: rd_addr_o/rd_data_o = granted rd/data, and reg_write_en_o=1 for exactly that cycle.
  - With no grant, reg_write_en_o=0; rd_addr_o and rd_data_o hold their previous values.
- x0:
  - A grant with rd=0 completes the handshake but produces reg_write_en_o=0.
  - busy bit 0 is never set.
- Scoreboard:
  - The issue edge sets busy[issue_rd_i]. Ignored when issue_rd_i=0.
  - A grant edge clears busy[granted rd]. busy_o is low in the same cycle reg_write_en_o is high.
  - Same register set and cleared on the same edge: set wins (new producer in flight), busy stays 1.
  - Different registers: both updates apply.
  - Clearing a bit that is not set has no effect and is not an error.
- Sustained throughput: one writeback per cycle.
- Reset mid-operation: a pending output write is dropped, busy is cleared, counters are zeroed. No write is issued on the first edge after reset release unless a grant occurs in that cycle.

Decomposition:
- Package sreg_wb_pkg holds:
  - wb_src_e enum (WB_ALU, WB_LSU, WB_MDU, WB_NONE)
  - wb_req_t struct {valid, rd[4:0], data}
  - NUM_WB_SRC = 3
- Sub-module sreg_scoreboard: busy bitmap with set/clear ports and set-wins rule.
- Arbiter, starvation counters and output register stay in the top module.

Test Plan:
- Single ALU write: alu_valid=1, rd=5, data=0xDEADBEEF for one cycle -> alu_ready=1 in cycle N; cycle N+1 shows reg_write_en=1, rd_addr=5, rd_data=0xDEADBEEF; cycle N+2 shows reg_write_en=0.
- All three sources valid (rd=1/2/3) -> grants in order ALU, LSU, MDU on consecutive cycles; three consecutive write pulses; each ready is high for exactly one cycle.
- ALU valid continuously for 10 cycles with LSU also valid -> LSU is granted on the cycle after its counter reaches 4 (5th cycle of waiting), and the ALU stalls one cycle.
- Issue rd=7 -> busy_o[7]=1; LSU writeback to rd=7 -> busy_o[7]=0 in the write cycle. Issue rd=7 on the same edge as a grant to rd=7 -> busy_o[7] stays 1.
- MDU result rd=0, data=0x1234 -> mdu_ready=1, reg_write_en stays 0, busy_o unchanged. Issue rd=0 -> busy_o[0] stays 0.
- Assert rst_n low while a grant is registered and busy=0x0000_0F00 -> reg_write_en=0 immediately, busy_o=0, all readies 0. After release, a fresh ALU write completes with latency 1.
